wisard_index_seq: RTL and testbench
===================================

WISARD_INDEX_SEQ -- requirements
Module: wisard_index_seq

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 5: width of the RAM index.
REQ-002 SHALL have parameter N_RAMS_MAX, default 27: maximum RAMs per discriminator frame.
REQ-003 SHALL have parameter LANES, default 1: RAM addresses carried per beat, legal range 1..N_RAMS_MAX.
REQ-004 SHALL have parameter DATA_WIDTH, default 16: payload width.
REQ-005 SHALL have parameter FCNT_WIDTH, default 16: frame counter width.
REQ-006 SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous clear
- n_rams  in  INDEX_WIDTH  frame length in RAMs, sampled at frame start
- sink_valid  in  1  input beat valid
- sink_ready  out  1  input beat accepted
- sink_sop  in  1  input start of frame
- sink_data  in  DATA_WIDTH  input payload
- src_valid  out  1  output beat valid
- src_ready  in  1  downstream ready
- src_data  out  DATA_WIDTH  output payload
- src_index  out  INDEX_WIDTH  base RAM index of the beat
- src_sop  out  1  first beat of frame
- src_eop  out  1  last beat of frame
- frame_cnt  out  FCNT_WIDTH  completed frames
- err_sop  out  1  sticky protocol error

Function
REQ-007 SHALL transfer an input beat when sink_valid && sink_ready, and an output beat when src_valid && src_ready.
REQ-008 SHALL drive sink_ready = !src_valid || src_ready; this is a single registered stage with 1-cycle latency and no bubble at full throughput.
REQ-009 SHALL hold src_* stable while src_valid && !src_ready.
REQ-010 SHALL keep internal next-index nxt. The assigned index is 0 if sink_sop, else nxt.
REQ-011 SHALL latch the effective length L at every accepted beat with assigned index 0. L = N_RAMS_MAX when n_rams == 0 or n_rams > N_RAMS_MAX, else n_rams.
REQ-012 SHALL set src_eop on a beat when assigned index + LANES >= L. On that beat nxt <= 0 and frame_cnt increments, wrapping modulo 2^FCNT_WIDTH.
REQ-013 SHALL otherwise set nxt <= assigned index + LANES. Beats per frame = ceil(L/LANES).
REQ-014 SHALL set src_sop when the assigned index is 0. A non-sop beat arriving with nxt == 0 is an implicit frame start.
REQ-015 SHALL handle sink_sop arriving with nxt != 0 as follows: abandon the current frame (no eop emitted, frame_cnt unchanged) and restart the frame at index 0 with the beat.
REQ-016 SHALL support a single-beat frame (L <= LANES): src_sop and src_eop both asserted.
REQ-017 SHALL ignore n_rams changes mid-frame.

Reset
REQ-018 SHALL, on rst_n low, asynchronously clear src_valid, src_sop, src_eop, src_index, src_data, nxt, frame_cnt and err_sop to 0, with L set to N_RAMS_MAX.
REQ-019 SHALL apply the same clear on clear == 1 at a clock edge. clear has priority over a simultaneous transfer, and the beat is dropped.
REQ-020 SHALL start the next accepted beat after a mid-frame reset or clear at index 0 with src_sop = 1.

Configuration
REQ-021 SHALL gate error detection with macro WISARD_INDEX_SEQ_ERR_EN.
- Defined: err_sop sets sticky on each REQ-015 event and clears only via reset or clear.
- Undefined: err_sop is tied to 0 and no detection logic is built; REQ-015 restart behaviour is unchanged.

Verification
REQ-022 SHALL cover LANES=1, n_rams=27, 27 beats with src_ready=1 -> src_index 0..26, src_sop on index 0, src_eop on 26, frame_cnt=1.
REQ-023 SHALL cover LANES=4, n_rams=27, 7 beats -> src_index 0,4,...,24, src_eop on 24, next frame starts at 0.
REQ-024 SHALL cover src_ready low 3 cycles mid-frame -> src outputs held, sink_ready=0, no beat lost or duplicated.
REQ-025 SHALL cover sink_sop at nxt=5 with ERR_EN defined -> src_index=0, src_sop=1, err_sop=1, frame_cnt unchanged.
REQ-026 SHALL cover n_rams=0, then n_rams=31, each with LANES=1 -> 27 beats per frame.
REQ-027 SHALL cover rst_n pulse at index 10 -> all outputs 0, next beat src_index=0 with src_sop=1.

Source files
------------

// File: rtl/wisard_index_seq.sv
// WiSARD RAM-index sequencer: one registered stage that tags each beat with its base RAM index,
// frame start/end flags and a completed-frame count. Optional sticky err_sop under WISARD_INDEX_SEQ_ERR_EN.
module wisard_index_seq #(
  parameter int INDEX_WIDTH = 5,
  parameter int N_RAMS_MAX  = 27,
  parameter int LANES       = 1,
  parameter int DATA_WIDTH  = 16,
  parameter int FCNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [INDEX_WIDTH-1:0] n_rams,
  input  logic                   sink_valid,
  output logic                   sink_ready,
  input  logic                   sink_sop,
  input  logic [DATA_WIDTH-1:0]  sink_data,
  output logic                   src_valid,
  input  logic                   src_ready,
  output logic [DATA_WIDTH-1:0]  src_data,
  output logic [INDEX_WIDTH-1:0] src_index,
  output logic                   src_sop,
  output logic                   src_eop,
  output logic [FCNT_WIDTH-1:0]  frame_cnt,
  output logic                   err_sop
);

  logic                   src_valid_q, src_valid_d;
  logic [DATA_WIDTH-1:0]  src_data_q, src_data_d;
  logic [INDEX_WIDTH-1:0] src_index_q, src_index_d;
  logic                   src_sop_q, src_sop_d;
  logic                   src_eop_q, src_eop_d;
  logic [INDEX_WIDTH-1:0] nxt_q, nxt_d;
  logic [INDEX_WIDTH-1:0] len_q, len_d;
  logic [FCNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;

  logic                   sink_fire;
  logic [INDEX_WIDTH-1:0] idx;
  logic [INDEX_WIDTH-1:0] len_new;
  logic [INDEX_WIDTH-1:0] len_eff;
  logic [31:0]            idx_sum;
  logic                   last_beat;

  assign sink_ready = !src_valid_q || src_ready;
  assign sink_fire  = sink_valid && sink_ready;

  always_comb begin
    idx = sink_sop ? '0 : nxt_q;
    if (n_rams == '0 || int'(n_rams) > N_RAMS_MAX) len_new = INDEX_WIDTH'(N_RAMS_MAX);
    else                                            len_new = n_rams;
    // A beat opening a frame must see its own freshly sampled length, not the stale one.
    len_eff   = (idx == '0) ? len_new : len_q;
    idx_sum   = 32'(idx) + 32'(LANES);
    last_beat = idx_sum >= 32'(len_eff);
  end

  always_comb begin
    src_valid_d = src_valid_q;
    src_data_d  = src_data_q;
    src_index_d = src_index_q;
    src_sop_d   = src_sop_q;
    src_eop_d   = src_eop_q;
    nxt_d       = nxt_q;
    len_d       = len_q;
    frame_cnt_d = frame_cnt_q;

    if (src_ready) src_valid_d = 1'b0;

    if (sink_fire) begin
      src_valid_d = 1'b1;
      src_data_d  = sink_data;
      src_index_d = idx;
      src_sop_d   = (idx == '0);
      src_eop_d   = last_beat;
      len_d       = len_eff;
      if (last_beat) begin
        nxt_d       = '0;
        frame_cnt_d = frame_cnt_q + FCNT_WIDTH'(1);
      end else begin
        nxt_d = INDEX_WIDTH'(idx_sum);
      end
    end

    if (clear) begin
      src_valid_d = 1'b0;
      src_data_d  = '0;
      src_index_d = '0;
      src_sop_d   = 1'b0;
      src_eop_d   = 1'b0;
      nxt_d       = '0;
      len_d       = INDEX_WIDTH'(N_RAMS_MAX);
      frame_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_valid_q <= 1'b0;
      src_data_q  <= '0;
      src_index_q <= '0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
      nxt_q       <= '0;
      len_q       <= INDEX_WIDTH'(N_RAMS_MAX);
      frame_cnt_q <= '0;
    end else begin
      src_valid_q <= src_valid_d;
      src_data_q  <= src_data_d;
      src_index_q <= src_index_d;
      src_sop_q   <= src_sop_d;
      src_eop_q   <= src_eop_d;
      nxt_q       <= nxt_d;
      len_q       <= len_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign src_valid = src_valid_q;
  assign src_data  = src_data_q;
  assign src_index = src_index_q;
  assign src_sop   = src_sop_q;
  assign src_eop   = src_eop_q;
  assign frame_cnt = frame_cnt_q;

`ifdef WISARD_INDEX_SEQ_ERR_EN
  logic err_sop_q, err_sop_d;

  // An explicit sop while a frame is still open abandons that frame.
  always_comb begin
    err_sop_d = err_sop_q;
    if (sink_fire && sink_sop && nxt_q != '0) err_sop_d = 1'b1;
    if (clear) err_sop_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_sop_q <= 1'b0;
    else        err_sop_q <= err_sop_d;
  end

  assign err_sop = err_sop_q;
`else
  assign err_sop = 1'b0;
`endif

endmodule

// File: tb/tb_wisard_index_seq.sv
// Directed bench for wisard_index_seq: one LANES=1 and one LANES=4 instance, hand-computed expectations.
module tb_wisard_index_seq;

  localparam int IW = 5;
  localparam int DW = 16;
  localparam int FW = 16;

`ifdef WISARD_INDEX_SEQ_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          clr   [2];
  logic [IW-1:0] nr    [2];
  logic          sv    [2];
  logic          srdy  [2];
  logic          ssop  [2];
  logic [DW-1:0] sdata [2];
  logic          ov    [2];
  logic          ordy  [2];
  logic [DW-1:0] odata [2];
  logic [IW-1:0] oidx  [2];
  logic          osop  [2];
  logic          oeop  [2];
  logic [FW-1:0] fcnt  [2];
  logic          err   [2];

  int n_checks = 0;
  int n_fail   = 0;

  wisard_index_seq #(.INDEX_WIDTH(IW), .N_RAMS_MAX(27), .LANES(1), .DATA_WIDTH(DW), .FCNT_WIDTH(FW)) u_l1 (
    .clk(clk), .rst_n(rst_n), .clear(clr[0]), .n_rams(nr[0]),
    .sink_valid(sv[0]), .sink_ready(srdy[0]), .sink_sop(ssop[0]), .sink_data(sdata[0]),
    .src_valid(ov[0]), .src_ready(ordy[0]), .src_data(odata[0]), .src_index(oidx[0]),
    .src_sop(osop[0]), .src_eop(oeop[0]), .frame_cnt(fcnt[0]), .err_sop(err[0])
  );

  wisard_index_seq #(.INDEX_WIDTH(IW), .N_RAMS_MAX(27), .LANES(4), .DATA_WIDTH(DW), .FCNT_WIDTH(FW)) u_l4 (
    .clk(clk), .rst_n(rst_n), .clear(clr[1]), .n_rams(nr[1]),
    .sink_valid(sv[1]), .sink_ready(srdy[1]), .sink_sop(ssop[1]), .sink_data(sdata[1]),
    .src_valid(ov[1]), .src_ready(ordy[1]), .src_data(odata[1]), .src_index(oidx[1]),
    .src_sop(osop[1]), .src_eop(oeop[1]), .frame_cnt(fcnt[1]), .err_sop(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one beat, let it be accepted on the next edge, then check the registered output.
  task automatic beat(input int u, input logic sop, input logic [DW-1:0] data,
                      input int exp_idx, input logic exp_sop, input logic exp_eop);
    sv[u]    = 1'b1;
    ssop[u]  = sop;
    sdata[u] = data;
    @(posedge clk); #1;
    check($sformatf("u%0d valid@%0d", u, exp_idx), 32'(ov[u]), 32'd1);
    check($sformatf("u%0d index@%0d", u, exp_idx), 32'(oidx[u]), 32'(exp_idx));
    check($sformatf("u%0d data@%0d", u, exp_idx), 32'(odata[u]), 32'(data));
    check($sformatf("u%0d sop@%0d", u, exp_idx), 32'(osop[u]), 32'(exp_sop));
    check($sformatf("u%0d eop@%0d", u, exp_idx), 32'(oeop[u]), 32'(exp_eop));
    sv[u]   = 1'b0;
    ssop[u] = 1'b0;
  endtask

  task automatic check_zero(input int u, input string tag);
    check({tag, " valid"}, 32'(ov[u]), 32'd0);
    check({tag, " index"}, 32'(oidx[u]), 32'd0);
    check({tag, " data"}, 32'(odata[u]), 32'd0);
    check({tag, " sop"}, 32'(osop[u]), 32'd0);
    check({tag, " eop"}, 32'(oeop[u]), 32'd0);
    check({tag, " fcnt"}, 32'(fcnt[u]), 32'd0);
    check({tag, " err"}, 32'(err[u]), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      clr[u] = 1'b0; nr[u] = 5'd27; sv[u] = 1'b0; ssop[u] = 1'b0;
      sdata[u] = '0; ordy[u] = 1'b1;
    end
    #1;
    check_zero(0, "rst l1");
    check_zero(1, "rst l4");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst sink_ready", 32'(srdy[0]), 32'd1);

    // LANES=1, n_rams=27: indices 0..26, one completed frame
    for (int k = 0; k < 27; k++)
      beat(0, k == 0, 16'(100 + k), k, k == 0, k == 26);
    check("l1 fcnt after frame", 32'(fcnt[0]), 32'd1);

    // LANES=4, n_rams=27: indices 0,4..24, eop on 24
    for (int k = 0; k < 7; k++)
      beat(1, k == 0, 16'(300 + k), 4 * k, k == 0, k == 6);
    check("l4 fcnt after frame", 32'(fcnt[1]), 32'd1);
    // Next frame starts at 0; L=3 <= LANES makes it a single-beat frame
    nr[1] = 5'd3;
    beat(1, 1'b0, 16'h0400, 0, 1'b1, 1'b1);
    check("l4 fcnt single beat", 32'(fcnt[1]), 32'd2);

    // Backpressure mid-frame: output held three cycles, nothing lost or repeated
    beat(0, 1'b0, 16'd200, 0, 1'b1, 1'b0);
    beat(0, 1'b0, 16'd201, 1, 1'b0, 1'b0);
    ordy[0] = 1'b0; sv[0] = 1'b1; sdata[0] = 16'd202;
    #1;
    check("stall sink_ready", 32'(srdy[0]), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d valid", c), 32'(ov[0]), 32'd1);
      check($sformatf("stall%0d index", c), 32'(oidx[0]), 32'd1);
      check($sformatf("stall%0d data", c), 32'(odata[0]), 32'd201);
      check($sformatf("stall%0d sink_ready", c), 32'(srdy[0]), 32'd0);
    end
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    check("unstall index", 32'(oidx[0]), 32'd2);
    check("unstall data", 32'(odata[0]), 32'd202);
    sv[0] = 1'b0;
    beat(0, 1'b0, 16'd203, 3, 1'b0, 1'b0);
    beat(0, 1'b0, 16'd204, 4, 1'b0, 1'b0);

    // Explicit sop with nxt=5 abandons the frame
    beat(0, 1'b1, 16'd250, 0, 1'b1, 1'b0);
    check("restart err_sop", 32'(err[0]), 32'(EXP_ERR));
    check("restart fcnt", 32'(fcnt[0]), 32'd1);

    // Clear wins over a simultaneous beat
    clr[0] = 1'b1; sv[0] = 1'b1; sdata[0] = 16'h5555;
    @(posedge clk); #1;
    clr[0] = 1'b0; sv[0] = 1'b0;
    check_zero(0, "clear");

    // n_rams=0 -> 27 beats; mid-frame n_rams change is ignored
    nr[0] = 5'd0;
    for (int k = 0; k < 27; k++) begin
      if (k == 10) nr[0] = 5'd4;
      beat(0, 1'b0, 16'(500 + k), k, k == 0, k == 26);
    end
    check("nrams0 fcnt", 32'(fcnt[0]), 32'd1);

    nr[0] = 5'd31;
    for (int k = 0; k < 27; k++)
      beat(0, k == 0, 16'(600 + k), k, k == 0, k == 26);
    check("nrams31 fcnt", 32'(fcnt[0]), 32'd2);

    nr[0] = 5'd1;
    beat(0, 1'b0, 16'd700, 0, 1'b1, 1'b1);
    check("single beat fcnt", 32'(fcnt[0]), 32'd3);

    // Asynchronous reset at index 10
    nr[0] = 5'd27;
    for (int k = 0; k <= 10; k++)
      beat(0, k == 0, 16'(800 + k), k, k == 0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_zero(0, "async rst");
    #2 rst_n = 1'b1;
    beat(0, 1'b0, 16'd900, 0, 1'b1, 1'b0);
    check("post rst fcnt", 32'(fcnt[0]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
